// File: rtl/rtext_frame_checker_if.sv
// rtext_frame_checker_if: sequencer code stream in, frame status and counters out
interface rtext_frame_checker_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
);
  logic [2:0] rtext;
  logic sample_en;
  logic clr_cnt;
  logic frame_ok;
  logic frame_err;
  logic in_frame;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [GAP_W-1:0] gap_len;
  modport master (
    output rtext, sample_en, clr_cnt,
    input frame_ok, frame_err, in_frame, frame_cnt, err_cnt, gap_len
  );
  modport slave (
    input rtext, sample_en, clr_cnt,
    output frame_ok, frame_err, in_frame, frame_cnt, err_cnt, gap_len
  );
endinterface

// File: rtl/rtext_frame_checker.sv
// rtext_frame_checker: checks 010,000,000,100,100 framing with a minimum 000 gap; counts good and bad frames
module rtext_frame_checker #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8,
  parameter int MIN_GAP = 2
) (
  input logic CLK,
  input logic RST,
  rtext_frame_checker_if.slave bus
);
  typedef enum logic [2:0] {HUNT, B1, B2, B3, B4, GAP} state_t;
  state_t state, nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n, gap_len_n;
  logic ok, err;
  always_comb begin
    nxt = state;
    gap_cnt_n = gap_cnt;
    gap_len_n = bus.gap_len;
    ok = 1'b0;
    err = 1'b0;
    if (bus.sample_en)
      case (state)
        HUNT: if (bus.rtext == 3'b010) begin
          nxt = B1;
          gap_len_n = '0;
        end
        B1: if (bus.rtext == 3'b000) nxt = B2; else err = 1'b1;
        B2: if (bus.rtext == 3'b000) nxt = B3; else err = 1'b1;
        B3: if (bus.rtext == 3'b100) nxt = B4; else err = 1'b1;
        B4: if (bus.rtext == 3'b100) begin
          nxt = GAP;
          ok = 1'b1;
          gap_cnt_n = '0;
        end else err = 1'b1;
        GAP: if (bus.rtext == 3'b000) gap_cnt_n = gap_cnt + GAP_W'(gap_cnt != '1);
        else if (bus.rtext == 3'b010 && gap_cnt >= GAP_W'(MIN_GAP)) begin
          nxt = B1;
          gap_len_n = gap_cnt;
        end else err = 1'b1;
        default: err = 1'b1;
      endcase
    if (err) nxt = HUNT;
  end
  // clear beats a same-edge increment; the pulses are unaffected
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= HUNT;
      gap_cnt <= '0;
      bus.frame_ok <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.in_frame <= 1'b0;
      bus.frame_cnt <= '0;
      bus.err_cnt <= '0;
      bus.gap_len <= '0;
    end else begin
      state <= nxt;
      gap_cnt <= gap_cnt_n;
      bus.gap_len <= gap_len_n;
      bus.frame_ok <= ok;
      bus.frame_err <= err;
      bus.in_frame <= nxt inside {B1, B2, B3, B4};
      bus.frame_cnt <= bus.clr_cnt ? '0 : bus.frame_cnt + CNT_W'(ok && bus.frame_cnt != '1);
      bus.err_cnt <= bus.clr_cnt ? '0 : bus.err_cnt + CNT_W'(err && bus.err_cnt != '1);
    end
endmodule
